// File: rtl/lc_1252_odd_ctrl.sv
// Job controller for the odd-cell count: folds [row,col] beats into parity bitmaps,
// scans the bitmaps, computes the odd-cell count and hands it off on a valid/ready port.
module lc_1252_odd_ctrl #(
   parameter int MAX_M       = 50,
   parameter int MAX_N       = 50,
   parameter int MAX_IND_LEN = 100,
   parameter int CNT_W       = $clog2(MAX_M * MAX_N + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [7:0]           i_m,
   input  logic [7:0]           i_n,
   input  logic [1:0][7:0]      i_ind_tdata,
   input  logic                 i_ind_tvalid,
   input  logic                 i_ind_tlast,
   output logic                 o_ind_tready,
   output logic [CNT_W-1:0]     o_odd_tdata,
   output logic                 o_odd_terr,
   output logic                 o_odd_tvalid,
   input  logic                 i_odd_tready,
   output logic                 o_busy
);

   localparam int RIW = (MAX_M > 1) ? $clog2(MAX_M) : 1;
   localparam int CIW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
   localparam int BW  = $clog2(MAX_IND_LEN + 2);
   localparam int PW  = CNT_W + 2;
   localparam logic [7:0]    MaxM8  = 8'(MAX_M);
   localparam logic [7:0]    MaxN8  = 8'(MAX_N);
   localparam logic [BW-1:0] LenMax = BW'(MAX_IND_LEN);
   localparam logic [BW-1:0] LenSat = BW'(MAX_IND_LEN + 1);

   typedef enum logic [1:0] {StLoad, StScan, StCalc, StOut} state_e;

   state_e             r_state, w_state_nxt;
   logic [MAX_M-1:0]   r_row_par;
   logic [MAX_N-1:0]   r_col_par;
   logic [BW-1:0]      r_cnt;
   logic               r_err;
   logic [7:0]         r_max_row, r_max_col;
   logic [7:0]         r_m, r_n, r_k;
   logic [7:0]         r_r_odd, r_c_odd;
   logic [CNT_W-1:0]   r_odd_tdata;
   logic               r_odd_terr;

   logic [7:0]         w_row, w_col, w_max_row, w_max_col, w_scan_len;
   logic               w_acc, w_bad_idx, w_over, w_job_err, w_scan_done;
   logic               w_row_bit, w_col_bit;
   logic [PW-1:0]      w_prod;

   assign w_row       = i_ind_tdata[0];
   assign w_col       = i_ind_tdata[1];
   assign w_acc       = i_ind_tvalid && o_ind_tready;
   assign w_bad_idx   = (w_row >= MaxM8) || (w_col >= MaxN8);
   assign w_over      = (r_cnt >= LenMax);
   assign w_max_row   = (w_row > r_max_row) ? w_row : r_max_row;
   assign w_max_col   = (w_col > r_max_col) ? w_col : r_max_col;
   // Maxima include the tlast beat itself, hence the combinational versions.
   assign w_job_err   = r_err || w_bad_idx || w_over || (i_m == 8'd0) || (i_n == 8'd0) ||
                        (i_m > MaxM8) || (i_n > MaxN8) || (w_max_row >= i_m) ||
                        (w_max_col >= i_n);
   assign w_scan_len  = (r_m > r_n) ? r_m : r_n;
   assign w_scan_done = (r_k == w_scan_len - 8'd1);
   assign w_row_bit   = (r_k < MaxM8) ? r_row_par[r_k[RIW-1:0]] : 1'b0;
   assign w_col_bit   = (r_k < MaxN8) ? r_col_par[r_k[CIW-1:0]] : 1'b0;
   assign w_prod      = PW'(r_r_odd) * PW'(r_n - r_c_odd) + PW'(r_m - r_r_odd) * PW'(r_c_odd);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= StLoad;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      o_ind_tready = !i_rst && (r_state == StLoad);
      o_odd_tvalid = (r_state == StOut);
      o_busy       = (r_state != StLoad);
      o_odd_tdata  = r_odd_tdata;
      o_odd_terr   = r_odd_terr;
      case (r_state)
         StLoad: if (w_acc && i_ind_tlast) w_state_nxt = w_job_err ? StCalc : StScan;
         StScan: if (w_scan_done) w_state_nxt = StCalc;
         StCalc: w_state_nxt = StOut;
         StOut:  if (i_odd_tready) w_state_nxt = StLoad;
         default: w_state_nxt = StLoad;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_row_par   <= '0;
         r_col_par   <= '0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_max_row   <= '0;
         r_max_col   <= '0;
         r_m         <= '0;
         r_n         <= '0;
         r_k         <= '0;
         r_r_odd     <= '0;
         r_c_odd     <= '0;
         r_odd_tdata <= '0;
         r_odd_terr  <= 1'b0;
      end else begin
         case (r_state)
            StLoad: if (w_acc) begin
               if (!w_bad_idx && !w_over) begin
                  r_row_par[w_row[RIW-1:0]] <= ~r_row_par[w_row[RIW-1:0]];
                  r_col_par[w_col[CIW-1:0]] <= ~r_col_par[w_col[CIW-1:0]];
               end
               if (r_cnt != LenSat) r_cnt <= r_cnt + BW'(1);
               r_max_row <= w_max_row;
               r_max_col <= w_max_col;
               if (i_ind_tlast) begin
                  r_m   <= i_m;
                  r_n   <= i_n;
                  r_err <= w_job_err;
                  r_k   <= '0;
               end else if (w_bad_idx || w_over) begin
                  r_err <= 1'b1;
               end
            end
            StScan: begin
               if (r_k < r_m) r_r_odd <= r_r_odd + {7'd0, w_row_bit};
               if (r_k < r_n) r_c_odd <= r_c_odd + {7'd0, w_col_bit};
               r_k <= r_k + 8'd1;
            end
            StCalc: begin
               r_odd_tdata <= r_err ? '0 : w_prod[CNT_W-1:0];
               r_odd_terr  <= r_err;
            end
            StOut: if (i_odd_tready) begin
               r_row_par <= '0;
               r_col_par <= '0;
               r_cnt     <= '0;
               r_err     <= 1'b0;
               r_max_row <= '0;
               r_max_col <= '0;
               r_k       <= '0;
               r_r_odd   <= '0;
               r_c_odd   <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule
